// File: rtl/pipe_hazard_ctrl.sv
// Hazard scheduler for the 5-stage pipeline.
// Tracks the destinations held in EX and MEM, stalls ID on any read-after-write
// dependency on them (no forwarding), flushes IF/ID on taken branches, and
// keeps saturating stall/flush statistics.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_freeze,
  input  logic [4:0]       in_id_rs_addr,
  input  logic [4:0]       in_id_rt_addr,
  input  logic             in_id_rs_rena,
  input  logic             in_id_rt_rena,
  input  logic [4:0]       in_id_rd_waddr,
  input  logic             in_id_rd_wena,
  input  logic             in_id_branch,
  output logic             out_pc_wena,
  output logic             out_ifid_wena,
  output logic             out_ifid_flush,
  output logic             out_idex_bubble,
  output logic             out_stall,
  output logic [4:0]       out_ex_waddr,
  output logic [4:0]       out_mem_waddr,
  output logic             out_ex_wena,
  output logic             out_mem_wena,
  output logic [CNT_W-1:0] out_stall_cycles,
  output logic [CNT_W-1:0] out_flush_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [4:0]       ex_waddr_q, ex_waddr_d;
  logic             ex_wena_q, ex_wena_d;
  logic [4:0]       mem_waddr_q, mem_waddr_d;
  logic             mem_wena_q, mem_wena_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic match_ex, match_mem, hazard, flush;

  // Operand compare against both scoreboard slots; $0 never matches.
  always_comb begin
    match_ex  = ex_wena_q && (ex_waddr_q != 5'd0) &&
                ((in_id_rs_rena && (in_id_rs_addr == ex_waddr_q)) ||
                 (in_id_rt_rena && (in_id_rt_addr == ex_waddr_q)));
    match_mem = mem_wena_q && (mem_waddr_q != 5'd0) &&
                ((in_id_rs_rena && (in_id_rs_addr == mem_waddr_q)) ||
                 (in_id_rt_rena && (in_id_rt_addr == mem_waddr_q)));
    hazard    = match_ex || match_mem;
    // A branch seen while stalled was resolved on stale operands.
    flush     = in_id_branch && !hazard && !in_freeze;
  end

  // Pipeline control outputs, combinational from ID inputs and the slots.
  always_comb begin
    out_stall        = hazard;
    out_pc_wena      = !hazard && !in_freeze;
    out_ifid_wena    = !hazard && !in_freeze;
    out_idex_bubble  = hazard && !in_freeze;
    out_ifid_flush   = flush;
    out_ex_waddr     = ex_waddr_q;
    out_ex_wena      = ex_wena_q;
    out_mem_waddr    = mem_waddr_q;
    out_mem_wena     = mem_wena_q;
    out_stall_cycles = stall_cnt_q;
    out_flush_count  = flush_cnt_q;
  end

  // Next state: slots shift EX->MEM, a stalled ID enters EX as a bubble.
  always_comb begin
    ex_waddr_d  = ex_waddr_q;
    ex_wena_d   = ex_wena_q;
    mem_waddr_d = mem_waddr_q;
    mem_wena_d  = mem_wena_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!in_freeze) begin
      mem_waddr_d = ex_waddr_q;
      mem_wena_d  = ex_wena_q;
      if (hazard) begin
        ex_waddr_d = 5'd0;
        ex_wena_d  = 1'b0;
        if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
        ex_waddr_d = in_id_rd_waddr;
        ex_wena_d  = in_id_rd_wena;
      end
      if (flush && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  // State registers; reset takes priority over freeze.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      ex_waddr_q  <= 5'd0;
      ex_wena_q   <= 1'b0;
      mem_waddr_q <= 5'd0;
      mem_wena_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_waddr_q  <= ex_waddr_d;
      ex_wena_q   <= ex_wena_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wena_q  <= mem_wena_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expected control outputs are queued
// when each ID step is driven and compared mid-cycle.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             in_clk = 1'b0;
  logic             in_rst;
  logic             in_freeze;
  logic [4:0]       in_id_rs_addr, in_id_rt_addr, in_id_rd_waddr;
  logic             in_id_rs_rena, in_id_rt_rena, in_id_rd_wena, in_id_branch;
  logic             out_pc_wena, out_ifid_wena, out_ifid_flush, out_idex_bubble, out_stall;
  logic [4:0]       out_ex_waddr, out_mem_waddr;
  logic             out_ex_wena, out_mem_wena;
  logic [CNT_W-1:0] out_stall_cycles, out_flush_count;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic stall;
    logic bubble;
    logic flush;
    logic pcw;
  } exp_t;

  exp_t exp_q[$];

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_freeze(in_freeze),
    .in_id_rs_addr(in_id_rs_addr), .in_id_rt_addr(in_id_rt_addr),
    .in_id_rs_rena(in_id_rs_rena), .in_id_rt_rena(in_id_rt_rena),
    .in_id_rd_waddr(in_id_rd_waddr), .in_id_rd_wena(in_id_rd_wena),
    .in_id_branch(in_id_branch),
    .out_pc_wena(out_pc_wena), .out_ifid_wena(out_ifid_wena),
    .out_ifid_flush(out_ifid_flush), .out_idex_bubble(out_idex_bubble),
    .out_stall(out_stall),
    .out_ex_waddr(out_ex_waddr), .out_mem_waddr(out_mem_waddr),
    .out_ex_wena(out_ex_wena), .out_mem_wena(out_mem_wena),
    .out_stall_cycles(out_stall_cycles), .out_flush_count(out_flush_count)
  );

  always #5 in_clk = ~in_clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic [4:0] rs, input logic rse, input logic [4:0] rt,
                        input logic rte, input logic [4:0] rd, input logic rde,
                        input logic br);
    in_id_rs_addr  = rs;  in_id_rs_rena = rse;
    in_id_rt_addr  = rt;  in_id_rt_rena = rte;
    in_id_rd_waddr = rd;  in_id_rd_wena = rde;
    in_id_branch   = br;
  endtask

  task automatic idle();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    in_freeze = 1'b0;
    in_rst    = 1'b0;
  endtask

  // Queue the expected outputs for the current inputs, check them mid-cycle,
  // then let one rising edge happen.
  task automatic step(input string tag, input logic stall, input logic bubble,
                      input logic flush, input logic pcw);
    exp_t e;
    exp_q.push_back('{stall: stall, bubble: bubble, flush: flush, pcw: pcw});
    @(negedge in_clk);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_stall"},  {31'd0, out_stall},       {31'd0, e.stall});
      chk({tag, "_bubble"}, {31'd0, out_idex_bubble}, {31'd0, e.bubble});
      chk({tag, "_flush"},  {31'd0, out_ifid_flush},  {31'd0, e.flush});
      chk({tag, "_pcw"},    {31'd0, out_pc_wena},     {31'd0, e.pcw});
      chk({tag, "_ifidw"},  {31'd0, out_ifid_wena},   {31'd0, e.pcw});
    end
    @(posedge in_clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    in_rst = 1'b1;
    @(posedge in_clk); #1;
    in_rst = 1'b0;
  endtask

  initial begin
    idle();
    // Reset with random ID inputs and freeze, held for two edges.
    in_rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_id(5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom),
             5'($urandom), 1'($urandom), 1'($urandom));
      in_freeze = 1'($urandom);
      @(posedge in_clk); #1;
    end
    idle();
    chk("rst_ex_waddr",  {27'd0, out_ex_waddr},  32'd0);
    chk("rst_mem_waddr", {27'd0, out_mem_waddr}, 32'd0);
    chk("rst_ex_wena",   {31'd0, out_ex_wena},   32'd0);
    chk("rst_mem_wena",  {31'd0, out_mem_wena},  32'd0);
    chk("rst_stall_cnt", {28'd0, out_stall_cycles}, 32'd0);
    chk("rst_flush_cnt", {28'd0, out_flush_count},  32'd0);
    step("rst_idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // Adjacent RAW on $3: two stall cycles.
    do_reset();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    step("adj_prod", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("adj_ex_waddr", {27'd0, out_ex_waddr}, 32'd3);
    set_id(5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    step("adj_s1", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("adj_mem_waddr", {27'd0, out_mem_waddr}, 32'd3);
    chk("adj_ex_wena_bubble", {31'd0, out_ex_wena}, 32'd0);
    step("adj_s2", 1'b1, 1'b1, 1'b0, 1'b0);
    step("adj_go", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("adj_stall_cnt", {28'd0, out_stall_cycles}, 32'd2);
    chk("adj_ex_after", {27'd0, out_ex_waddr}, 32'd4);

    // Distance-2 RAW on $5 through rt: one stall cycle.
    do_reset();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    step("d2_prod", 1'b0, 1'b0, 1'b0, 1'b1);
    set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
    step("d2_indep", 1'b0, 1'b0, 1'b0, 1'b1);
    set_id(5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    step("d2_s1", 1'b1, 1'b1, 1'b0, 1'b0);
    step("d2_go", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("d2_stall_cnt", {28'd0, out_stall_cycles}, 32'd1);

    // Same pattern with producer $0: recorded but never matches.
    do_reset();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    step("z_prod", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("z_ex_wena", {31'd0, out_ex_wena}, 32'd1);
    set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
    step("z_adj", 1'b0, 1'b0, 1'b0, 1'b1);
    set_id(5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    step("z_rd", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("z_stall_cnt", {28'd0, out_stall_cycles}, 32'd0);

    // Branch without hazard: one flush.
    do_reset();
    set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1);
    step("br_flush", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("br_flush_cnt", {28'd0, out_flush_count}, 32'd1);
    idle();
    step("br_idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // Branch during a hazard on $7: held off until ID is released.
    do_reset();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    step("brh_prod", 1'b0, 1'b0, 1'b0, 1'b1);
    set_id(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    step("brh_s1", 1'b1, 1'b1, 1'b0, 1'b0);
    step("brh_s2", 1'b1, 1'b1, 1'b0, 1'b0);
    step("brh_go", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("brh_flush_cnt", {28'd0, out_flush_count}, 32'd1);

    // Freeze for three cycles in the middle of an adjacent-RAW stall.
    do_reset();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    step("fz_prod", 1'b0, 1'b0, 1'b0, 1'b1);
    set_id(5'd3, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    step("fz_s1", 1'b1, 1'b1, 1'b0, 1'b0);
    in_freeze = 1'b1;
    for (int i = 0; i < 3; i++) step("fz_hold", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fz_mem_waddr", {27'd0, out_mem_waddr}, 32'd3);
    chk("fz_mem_wena",  {31'd0, out_mem_wena},  32'd1);
    chk("fz_stall_cnt_hold", {28'd0, out_stall_cycles}, 32'd1);
    in_freeze = 1'b0;
    step("fz_s2", 1'b1, 1'b1, 1'b0, 1'b0);
    step("fz_go", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("fz_stall_cnt", {28'd0, out_stall_cycles}, 32'd2);

    // Reset asserted mid-stall (together with freeze) clears the stall.
    do_reset();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    step("rs_prod", 1'b0, 1'b0, 1'b0, 1'b1);
    set_id(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step("rs_s1", 1'b1, 1'b1, 1'b0, 1'b0);
    in_rst = 1'b1;
    in_freeze = 1'b1;
    @(posedge in_clk); #1;
    in_rst = 1'b0;
    in_freeze = 1'b0;
    step("rs_clear", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rs_stall_cnt", {28'd0, out_stall_cycles}, 32'd0);

    // Saturation: 20 stall cycles into a 4-bit counter.
    do_reset();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    step("sat_prod", 1'b0, 1'b0, 1'b0, 1'b1);
    set_id(5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) begin
      if ((i % 3) == 2) step("sat_go", 1'b0, 1'b0, 1'b0, 1'b1);
      else              step("sat_st", 1'b1, 1'b1, 1'b0, 1'b0);
    end
    chk("sat_stall_cnt", {28'd0, out_stall_cycles}, 32'd15);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central hazard scheduler for the 5-stage MIPS pipeline. It keeps its own scoreboard of the destination registers held by the instructions in EX and MEM, and compares the operands of the instruction in ID against it. From that it drives the PC / IF-ID write enables, the ID-EX bubble and the IF-ID flush for taken branches. It also keeps saturating stall and flush statistics counters for the testbench.

## Interface
Parameters:
- CNT_W, 32, width of the statistics counters.

Ports:
- in_clk  input  1  system clock; all state updates on the rising edge.
- in_rst  input  1  synchronous, active-high reset.
- in_freeze  input  1  global hold (e.g. memory busy); while high, no internal state advances.
- in_id_rs_addr  input  5  rs field of the ID instruction.
- in_id_rt_addr  input  5  rt field of the ID instruction.
- in_id_rs_rena  input  1  the ID instruction reads rs.
- in_id_rt_rena  input  1  the ID instruction reads rt.
- in_id_rd_waddr  input  5  destination register of the ID instruction.
- in_id_rd_wena  input  1  the ID instruction writes the register file.
- in_id_branch  input  1  branch/jump resolved as taken in ID.
- out_pc_wena  output  1  PC register update enable.
- out_ifid_wena  output  1  IF/ID register update enable.
- out_ifid_flush  output  1  load a NOP into IF/ID on this edge.
- out_idex_bubble  output  1  load a NOP into ID/EX on this edge.
- out_stall  output  1  data hazard detected this cycle.
- out_ex_waddr, out_mem_waddr  output  5  scoreboard destinations (debug).
- out_ex_wena, out_mem_wena  output  1  scoreboard valid bits (debug).
- out_stall_cycles  output  CNT_W  count of cycles with out_stall=1 and in_freeze=0.
- out_flush_count  output  CNT_W  count of issued IF/ID flushes.

## Operation
- Scoreboard: two slots, EX{waddr, wena} and MEM{waddr, wena}.
- A slot matches when its wena=1, its waddr!=0, and its waddr equals an operand address whose rena is 1.
- hazard = match(EX) | match(MEM). The WB stage is not checked: the register file is write-first, so a WB write is visible to ID in the same cycle.
- No forwarding. A dependency stalls ID until the producer has left MEM.
- Combinational outputs:
  - out_stall = hazard.
  - out_pc_wena = out_ifid_wena = !hazard & !in_freeze.
  - out_idex_bubble = hazard & !in_freeze.
  - out_ifid_flush = in_id_branch & !hazard & !in_freeze. A branch seen during a stall uses stale operands and is ignored.
- Sequential update, when in_freeze=0:
  - MEM <= EX.
  - If hazard, EX <= {0, 0}; otherwise EX <= {in_id_rd_waddr, in_id_rd_wena}.
- Sequential update, when in_freeze=1: all state, including the counters, holds.
- Counters: out_stall_cycles increments on edges where hazard & !in_freeze; out_flush_count increments on edges where out_ifid_flush=1. Both saturate at 2^CNT_W-1.
- Writes to $0 are entered in the scoreboard but never match.

## Timing
- Reset (in_rst=1 at an edge): both slots <= {0, 0}; both counters <= 0.
- Outputs after reset, with idle inputs: out_stall=0, out_pc_wena=1, out_ifid_wena=1, out_ifid_flush=0, out_idex_bubble=0, all debug outputs 0.
- Reset overrides in_freeze. Reset asserted mid-stall clears the stall on the next cycle.
- All control outputs are combinational from the current inputs and the registered slots, so they are valid in the same cycle as the ID inputs.
- Stall length for a dependent instruction at distance d behind its producer:
  - d=1 (adjacent): 2 cycles.
  - d=2: 1 cycle.
  - d>=3: 0 cycles.
- Simultaneous hazard and branch: stall wins, no flush. The branch is re-evaluated once ID is released.
- Simultaneous freeze and hazard: out_stall=1, out_idex_bubble=0, no counter change.

## Test plan
- Reset: hold in_rst 2 cycles with random inputs -> slots, debug outputs and counters are 0; out_pc_wena=1.
- Adjacent RAW: ID writes $3 (wena=1), next ID reads rs=$3 -> out_stall=1 for exactly 2 cycles; 2 bubbles; out_stall_cycles=2; issue resumes on the 3rd cycle.
- Distance-2 RAW and $0: producer $5, one independent instruction, then a reader of rt=$5 -> 1 stall cycle. Repeat with producer $0 -> 0 stalls.
- Branch: in_id_branch=1 with no hazard -> out_ifid_flush=1 for 1 cycle; out_flush_count=1. With in_id_branch=1 during a hazard on $7 -> no flush until the stall clears, then exactly 1 flush.
- Freeze: assert in_freeze for 3 cycles in the middle of an adjacent-RAW stall -> scoreboard and counters hold. After release, the remaining stall cycles complete; total out_stall_cycles=2.
- Saturation: CNT_W=4, force 20 stall cycles -> out_stall_cycles stops at 15.
